seq_mult: RTL

Iterative shift-add multiplier that produces a 2·WWidth-bit product from two WWidth-bit operands, one partial-product step per clock. It is the multiply counterpart to the combinational divider in the MIPS datapath and serves MULT/MULTU, writing HI/LO through a start/done handshake. Trading latency for area keeps the multiply path off the critical path.

---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/seq_mult_adder.sv | 14 +
 rtl/seq_mult.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Used by seq_mult (see that file for the SEQ_MULT_SIGNED_EN build option).
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Bits needed to hold an iteration count running from w down to 0.
   function automatic int count_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_mult_adder.sv
// AdderN: plain N-bit ripple adder with carry-in; the sum wraps modulo 2^N.
// Used for the accumulate step and for the two's-complement fix-up.
module AdderN #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum
);

   assign sum = a + b + {{(N-1){1'b0}}, cin};

endmodule

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, one partial-product step per clock.
// Produces a 2*WWidth-bit product of two WWidth-bit operands behind a
// start/done handshake (MULT/MULTU path feeding HI/LO).
//
// Build option SEQ_MULT_SIGNED_EN: when defined, signed_op=1 selects a signed
// multiply (magnitudes are multiplied, then the FIX state negates the result
// if the operand signs differ). When undefined, signed_op is ignored and every
// operation is unsigned.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one shift-add iteration per edge, count runs WWidth -> 0
// FIX   | signed build only: conditional negation of the raw product
// DONE  | product just updated, done pulses; start here is accepted
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WWidth = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WWidth-1:0]     multiplicand,
   input  logic [WWidth-1:0]     multiplier,
   input  logic                  signed_op,
   output logic                  busy,
   output logic                  done,
   output logic [2*WWidth-1:0]   product
);

   localparam int W  = WWidth;
   localparam int CW = count_width(WWidth);

   state_e          state_q, state_d;
   logic [2*W:0]    p_q, p_d;
   logic [W-1:0]    mcand_q, mcand_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2*W-1:0]  product_q, product_d;

   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W:0]      acc_sum;
   logic [W:0]      acc_next;
   logic [2*W:0]    p_shift;

   // Accumulate: upper W+1 bits of P plus the latched multiplicand, carry kept
   // in the top bit so the add never overflows.
   AdderN #(.N(W + 1)) u_acc_add (
      .a   (p_q[2*W:W]),
      .b   ({1'b0, mcand_q}),
      .cin (1'b0),
      .sum (acc_sum)
   );

   // One iteration: conditional add on P[0], then shift the whole of P right.
   always_comb begin
      acc_next = p_q[0] ? acc_sum : p_q[2*W:W];
      p_shift  = {1'b0, acc_next, p_q[W-1:1]};
   end

`ifdef SEQ_MULT_SIGNED_EN
   logic            sign_q, sign_d;
   logic            load_sign;
   logic [2*W-1:0]  fix_a;
   logic [2*W-1:0]  fix_res;

   // Two's-complement negation as ~P + 1; passes P through when sign is clear.
   AdderN #(.N(2 * W)) u_fix_add (
      .a   (fix_a),
      .b   ('0),
      .cin (sign_q),
      .sum (fix_res)
   );

   // Operand conditioning: signed requests are reduced to magnitudes. The
   // magnitude of -2^(W-1) is 2^(W-1), which still fits unsigned in W bits.
   always_comb begin
      load_sign = signed_op & (multiplicand[W-1] ^ multiplier[W-1]);
      op_a      = (signed_op && multiplicand[W-1]) ? (~multiplicand + W'(1)) : multiplicand;
      op_b      = (signed_op && multiplier[W-1])   ? (~multiplier + W'(1))   : multiplier;
      fix_a     = sign_q ? ~p_q[2*W-1:0] : p_q[2*W-1:0];
   end

   // Result sign, captured with the operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sign_q <= 1'b0;
      else        sign_q <= sign_d;
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;

   // Unsigned-only build: operands pass straight through.
   always_comb begin
      op_a = multiplicand;
      op_b = multiplier;
   end
`endif

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      mcand_d   = mcand_q;
      count_d   = count_q;
      product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
      sign_d    = sign_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               p_d     = {(W + 1)'(0), op_b};
               mcand_d = op_a;
               count_d = CW'(W);
`ifdef SEQ_MULT_SIGNED_EN
               sign_d  = load_sign;
`endif
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            p_d     = p_shift;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
`ifdef SEQ_MULT_SIGNED_EN
               state_d   = FIX;
`else
               product_d = p_shift[2*W-1:0];
               state_d   = DONE;
`endif
            end
         end
`ifdef SEQ_MULT_SIGNED_EN
         FIX: begin
            p_d       = {1'b0, fix_res};
            product_d = fix_res;
            state_d   = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         p_q       <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         mcand_q   <= mcand_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN) || (state_q == FIX);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule
